// File: rtl/turbo_pkg.sv
// Shared constants and types for the LTE turbo-code constituent RSC datapath.
package turbo_pkg;

  localparam int KMIN_C   = 40;
  localparam int KMAX_C   = 6144;
  localparam int TAIL_LEN = 3;

  // Polynomials indexed by delay: bit i is the D^i coefficient.
  localparam logic [3:0] G0_POLY = 4'b1101;  // 1 + D^2 + D^3 (feedback)
  localparam logic [3:0] G1_POLY = 4'b1011;  // 1 + D + D^3   (parity)

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/rsc_trellis_step.sv
// One combinational step of the RSC trellis; state_i[0] is s1 (newest), state_i[2] is s3.
module rsc_trellis_step
  import turbo_pkg::*;
(
  input  logic       tail_i,
  input  logic [2:0] state_i,
  input  logic       sys_i,
  output logic [2:0] next_o,
  output logic       parity_o,
  output logic       fb_o
);

  logic a;

  // During termination the systematic bit equals the feedback, so the register input is zero.
  assign fb_o     = ^(G0_POLY[3:1] & state_i);
  assign a        = tail_i ? 1'b0 : (sys_i ^ fb_o);
  assign parity_o = (G1_POLY[0] & a) ^ (^(G1_POLY[3:1] & state_i));
  assign next_o   = {state_i[1:0], a};

endmodule

// File: rtl/rsc_hd_decoder.sv
// Hard-decision RSC checker: passes systematic bits through, counts parity mismatches, checks termination.
module rsc_hd_decoder
  import turbo_pkg::*;
#(
  parameter int KMIN = KMIN_C,
  parameter int KMAX = KMAX_C,
  parameter int CW   = 13
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic [31:0]   K,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          xk,
  input  logic          zk,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          ck,
  output logic          ck_last,
  output logic          busy,
  output logic          done,
  output logic          len_err,
  output logic          tail_err,
  output logic [CW-1:0] err_count
);

  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] TAIL_END = CW'(TAIL_LEN - 1);

  state_e        state_q;
  logic [2:0]    trel_q;
  logic [CW-1:0] step_q;
  logic [CW-1:0] klen_q;
  logic [CW-1:0] err_q;
  logic          tail_err_q;
  logic          ck_q;
  logic          ck_last_q;
  logic          out_valid_q;
  logic          done_q;
  logic          len_err_q;

  logic [2:0]    trel_d;
  logic          par_exp;
  logic          fb;
  logic          acc;
  logic          k_ok;
  logic          last_data;
  logic          tail_bad;

  rsc_trellis_step u_step (
    .tail_i   (state_q == TAIL),
    .state_i  (trel_q),
    .sys_i    (xk),
    .next_o   (trel_d),
    .parity_o (par_exp),
    .fb_o     (fb)
  );

  assign in_ready  = ((state_q == DATA) && (!out_valid_q || out_ready)) || (state_q == TAIL);
  assign acc       = in_valid && in_ready;
  assign k_ok      = (K >= 32'(KMIN)) && (K <= 32'(KMAX));
  assign last_data = (step_q == (klen_q - ONE));
  assign tail_bad  = (xk != fb) || (zk != par_exp);

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q     <= IDLE;
      trel_q      <= 3'b000;
      step_q      <= '0;
      klen_q      <= '0;
      err_q       <= '0;
      tail_err_q  <= 1'b0;
      ck_q        <= 1'b0;
      ck_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
      // A load in DATA below overrides this drain.
      if (out_ready) out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !out_valid_q) begin
            if (k_ok) begin
              klen_q     <= K[CW-1:0];
              err_q      <= '0;
              tail_err_q <= 1'b0;
              step_q     <= '0;
              trel_q     <= 3'b000;
              state_q    <= DATA;
            end else begin
              len_err_q <= 1'b1;
            end
          end
        end
        DATA: begin
          if (acc) begin
            if ((zk != par_exp) && (err_q != '1)) err_q <= err_q + ONE;
            trel_q      <= trel_d;
            ck_q        <= xk;
            ck_last_q   <= last_data;
            out_valid_q <= 1'b1;
            if (last_data) begin
              step_q  <= '0;
              state_q <= TAIL;
            end else begin
              step_q <= step_q + ONE;
            end
          end
        end
        TAIL: begin
          if (acc) begin
            trel_q <= trel_d;
            if (tail_bad) tail_err_q <= 1'b1;
            if (step_q == TAIL_END) begin
              if (trel_d != 3'b000) tail_err_q <= 1'b1;
              step_q  <= '0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              step_q <= step_q + ONE;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign ck        = ck_q;
  assign ck_last   = ck_last_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign len_err   = len_err_q;
  assign tail_err  = tail_err_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_rsc_hd_decoder.sv
// Directed bench for rsc_hd_decoder; stimulus parity comes from a bench-side RSC encoder.
module tb_rsc_hd_decoder;

  logic        clk = 1'b0;
  logic        aclr;
  logic [31:0] K;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic        xk;
  logic        zk;
  logic        out_valid;
  logic        out_ready;
  logic        ck;
  logic        ck_last;
  logic        busy;
  logic        done;
  logic        len_err;
  logic        tail_err;
  logic [12:0] err_count;

  int errors = 0;
  int checks = 0;

  bit dat[6144];
  bit rx_ck[$];
  bit rx_last[$];

  rsc_hd_decoder dut (
    .clk       (clk),
    .aclr      (aclr),
    .K         (K),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .xk        (xk),
    .zk        (zk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ck        (ck),
    .ck_last   (ck_last),
    .busy      (busy),
    .done      (done),
    .len_err   (len_err),
    .tail_err  (tail_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, so a handshake seen here completes at the next posedge.
  always @(negedge clk) begin
    if (aclr && out_valid && out_ready) begin
      rx_ck.push_back(ck);
      rx_last.push_back(ck_last);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic drive_beat(input bit x, input bit z, output bit ok);
    in_valid = 1'b1;
    xk = x;
    zk = z;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic start_blk(input int kk);
    @(posedge clk);
    #1;
    K = kk;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_block(input string tag, input int kk, input int flip_a, input int flip_b,
                           input int tail_flip, input int stall_k, input int exp_err,
                           input bit exp_tail);
    bit b1, b2, b3, a, x, z, ok;
    int tmo, stall_hi, ck_bad, last_bad;
    b1 = 0; b2 = 0; b3 = 0;
    tmo = 0; stall_hi = 0; ck_bad = 0; last_bad = 0;
    rx_ck.delete();
    rx_last.delete();
    start_blk(kk);
    chk({tag, "_busy_start"}, busy, 1);
    for (int k = 0; k < kk; k++) begin
      if (k == stall_k) begin
        out_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          if (in_ready) stall_hi++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        chk({tag, "_stall_in_ready_hi"}, stall_hi, 0);
      end
      x = dat[k];
      a = x ^ b2 ^ b3;
      z = a ^ b1 ^ b3 ^ ((k == flip_a) || (k == flip_b));
      b3 = b2; b2 = b1; b1 = a;
      drive_beat(x, z, ok);
      if (!ok) tmo++;
    end
    for (int t = 0; t < 3; t++) begin
      x = b2 ^ b3;
      z = b1 ^ b3 ^ (t == tail_flip);
      b3 = b2; b2 = b1; b1 = 1'b0;
      drive_beat(x, z, ok);
      if (!ok) tmo++;
    end
    chk({tag, "_timeouts"}, tmo, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 1);
    chk({tag, "_err_count"}, err_count, exp_err);
    chk({tag, "_tail_err"}, tail_err, exp_tail);
    @(negedge clk);
    chk({tag, "_done_clear"}, done, 0);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_ck_count"}, rx_ck.size(), kk);
    for (int i = 0; i < rx_ck.size() && i < kk; i++) begin
      if (rx_ck[i] != dat[i]) ck_bad++;
      if (rx_last[i] != (i == kk - 1)) last_bad++;
    end
    chk({tag, "_ck_data"}, ck_bad, 0);
    chk({tag, "_ck_last"}, last_bad, 0);
  endtask

  initial begin
    bit ok;
    aclr = 1'b0;
    K = 32'd0;
    start = 1'b0;
    in_valid = 1'b0;
    xk = 1'b0;
    zk = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ck", ck, 0);
    chk("rst_ck_last", ck_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_tail_err", tail_err, 0);
    chk("rst_err_count", err_count, 0);
    aclr = 1'b1;

    for (int i = 0; i < 6144; i++) dat[i] = 1'b0;
    run_block("zero40", 40, -1, -1, -1, -1, 0, 1'b0);

    dat[0] = 1'b1;
    run_block("imp40", 40, -1, -1, -1, -1, 0, 1'b0);
    run_block("flip40", 40, 5, 17, -1, -1, 2, 1'b0);
    run_block("tailbad40", 40, -1, -1, 1, -1, 0, 1'b1);

    for (int i = 0; i < 100; i++) dat[i] = 1'($urandom_range(0, 1));
    run_block("stall100", 100, -1, -1, -1, 50, 0, 1'b0);

    @(posedge clk); #1;
    K = 32'd39; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("k39_len_err", len_err, 1);
    chk("k39_busy", busy, 0);
    chk("k39_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("k39_len_err_clear", len_err, 0);
    K = 32'd6145; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("k6145_len_err", len_err, 1);
    chk("k6145_busy", busy, 0);
    chk("k6145_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("k6145_len_err_clear", len_err, 0);

    for (int i = 0; i < 6144; i++) dat[i] = 1'($urandom_range(0, 1));
    start_blk(6144);
    begin
      bit b1, b2, b3, a;
      b1 = 0; b2 = 0; b3 = 0;
      for (int k = 0; k < 20; k++) begin
        a = dat[k] ^ b2 ^ b3;
        drive_beat(dat[k], a ^ b1 ^ b3 ^ (k == 3), ok);
        b3 = b2; b2 = b1; b1 = a;
      end
    end
    chk("mid_busy_before_rst", busy, 1);
    aclr = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_ck_last", ck_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err_count", err_count, 0);
    chk("mid_rst_tail_err", tail_err, 0);
    @(posedge clk); #1;
    aclr = 1'b1;
    run_block("full6144", 6144, -1, -1, -1, -1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rsc_hd_decoder.md
# rsc_hd_decoder

Hard-decision receive-side checker/decoder for the constituent RSC code of the turbo encoder (LTE code: feedback g0 = 1+D²+D³, parity g1 = 1+D+D³). It consumes one (xk, zk) pair per accepted beat for K data steps plus 3 trellis-termination steps. It recovers ck from the systematic stream, re-encodes it to count parity mismatches, and checks that the tail returns the trellis to state zero. It sits on the receive path opposite encoder e1, ahead of any soft decoder, and serves as a link/self-test monitor.

## Interface
Parameters:
- KMIN, 40, smallest legal block length
- KMAX, 6144, largest legal block length
- CW, 13, width of err_count and the internal step counter

Ports:
- clk  in  1  single clock; all logic rising-edge
- aclr  in  1  asynchronous, active-low reset
- K  in  32  block length, sampled only on an accepted start
- start  in  1  begin block; honoured only in IDLE
- in_valid  in  1  xk/zk pair present
- in_ready  out  1  pair accepted when in_valid && in_ready
- xk  in  1  received systematic bit
- zk  in  1  received parity bit
- out_valid  out  1  ck holds a decoded bit
- out_ready  in  1  downstream accepts ck
- ck  out  1  decoded information bit
- ck_last  out  1  qualifies the final ck of the block (k = K-1)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at block end
- len_err  out  1  one-cycle pulse when start carries K outside [KMIN, KMAX]
- tail_err  out  1  trellis not zero after tail; held until next accepted start
- err_count  out  CW  data-phase parity mismatches; held until next accepted start

## Operation
- States: IDLE, DATA, TAIL, DONE.
- Trellis state s1,s2,s3 (s1 newest), reset to 000 on an accepted start.
- IDLE: start with K in range latches K, clears err_count/tail_err/step counter, goes to DATA. Out-of-range K pulses len_err next cycle and stays in IDLE. in_ready = 0.
- DATA, per accepted pair:
  - a = xk^s2^s3; expected parity p = a^s1^s3.
  - If zk != p, err_count += 1, saturating at 2^CW-1.
  - State shifts: s3<=s2, s2<=s1, s1<=a.
  - Register ck = xk and ck_last = (k == K-1); assert out_valid.
  - After step K-1, go to TAIL.
- TAIL, 3 accepted pairs:
  - Expected tail bits: xk = s2^s3 and zk = s1^s3; the feedback bit is forced to 0.
  - Any mismatch, or state != 000 after the third pair, sets tail_err.
  - No ck output. Go to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- in_ready:
  - DATA: (!out_valid || out_ready).
  - TAIL: 1.
  - IDLE/DONE: 0.
- start outside IDLE is ignored.
- Output register: out_valid clears on out_ready when no new bit is loaded that cycle. Simultaneous drain and load keeps out_valid = 1 with the new data.
- The final ck may still be pending while in TAIL/DONE/IDLE. It is held until out_ready; a new start is not accepted until out_valid = 0.

## Timing
- Reset values: in_ready 0, out_valid 0, ck 0, ck_last 0, busy 0, done 0, len_err 0, tail_err 0, err_count 0, state IDLE, trellis 000.
- Latency: ck is valid the cycle after the pair is accepted.
- Full throughput: 1 pair/cycle with out_ready held high.
- Minimum block time: K+3 accepted beats + 1 DONE cycle. Data and tail beats are back-to-back with no bubble.
- done is asserted the cycle after the third tail beat; err_count and tail_err are final in that same cycle.
- aclr mid-block returns every register to its reset value at once. Any partially delivered block is abandoned.

## Structure
- Package turbo_pkg holds:
  - KMIN and KMAX constants
  - g0/g1 polynomial constants
  - state enum (IDLE, DATA, TAIL, DONE)
  - the tail length constant 3
- Sub-module rsc_trellis_step (combinational):
  - inputs: state, systematic bit, tail flag
  - outputs: next state and expected parity
  - shareable with a future encoder self-check

## Test plan
- K=40, all xk=zk=0, tail all zero -> 40 ck=0 with ck_last on the 40th; err_count=0, tail_err=0; done 1 cycle after the 43rd beat.
- K=40, xk=1 at k=0 only, zk from the reference model (first four zk = 1,1,1,1), correct tail -> ck mirrors xk, err_count=0, tail_err=0.
- Same stream with zk inverted at k=5 and k=17 -> err_count=2, ck unchanged, tail_err=0.
- Correct K=100 stream with out_ready low for 10 cycles at k=50 -> in_ready low during the stall; all 100 ck delivered in order; no loss or duplication.
- start with K=39, then K=6145 -> len_err pulse each time; busy stays 0; in_ready stays 0.
- aclr pulsed at k=20 of K=6144 -> all outputs at reset values next cycle; a following full K=6144 block completes with err_count=0.
